// File: rtl/lsu_split_ctrl_pkg.sv
// Shared types and helpers for the load/store split sequencer.
package lsu_split_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_GNT_2,
    WAIT_RVALID_2
  } lsu_split_state_e;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  // The unused encoding 2'b11 behaves as a word access.
  function automatic lsu_type_e decode_type(input logic [1:0] t);
    case (t)
      2'b01:   return LSU_HALF;
      2'b10:   return LSU_BYTE;
      default: return LSU_WORD;
    endcase
  endfunction

  function automatic logic needs_split(input lsu_type_e t, input logic [1:0] o);
    return ((t == LSU_WORD) && (o != 2'd0)) || ((t == LSU_HALF) && (o == 2'd3));
  endfunction

  // Low nibble is the first access, high nibble the spill into the next word.
  function automatic logic [7:0] be_span(input lsu_type_e t, input logic [1:0] o);
    logic [7:0] base;
    case (t)
      LSU_HALF: base = 8'h03;
      LSU_BYTE: base = 8'h01;
      default:  base = 8'h0F;
    endcase
    return base << o;
  endfunction

endpackage

// File: rtl/lsu_rdata_align.sv
// Load data realignment: shifts {word1,word0} down by the byte offset, then masks and extends.
module lsu_rdata_align
  import lsu_split_ctrl_pkg::*;
(
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  input  logic [1:0]  offset_i,
  input  lsu_type_e   type_i,
  input  logic        sign_ext_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = 32'({word1_i, word0_i} >> {offset_i, 3'b000});

  always_comb begin
    rdata_o = shifted;
    case (type_i)
      LSU_HALF: rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      LSU_BYTE: rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      default:  ;
    endcase
  end

endmodule

// File: rtl/lsu_split_ctrl.sv
// Load/store sequencer; misaligned accesses are split into two bus transactions
// only when LSU_MISALIGNED_EN is defined, otherwise they fault immediately.
module lsu_split_ctrl
  import lsu_split_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] adder_result_ex_i,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i,
  output logic        lsu_addr_incr_req_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] lsu_rdata_o
);

  lsu_split_state_e state_q, state_d;
  logic [1:0]  offset_q;
  lsu_type_e   type_q;
  logic        we_q, sign_ext_q;
  logic [31:0] addr_q, word0_q;

  lsu_type_e   type_in, type_cur;
  logic [1:0]  off_in, off_cur;
  logic [31:0] word_addr;
  logic        split_in, split_q;
  logic        accept, latch_word0, be_hi, rdata_valid;
  logic [7:0]  span;
  logic [31:0] wdata_rot, aligned, word0_sel;

  assign type_in   = decode_type(lsu_type_i);
  assign off_in    = adder_result_ex_i[1:0];
  assign word_addr = {adder_result_ex_i[31:2], 2'b00};
  assign split_in  = needs_split(type_in, off_in);
`ifdef LSU_MISALIGNED_EN
  assign split_q   = needs_split(type_q, offset_q);
`else
  assign split_q   = 1'b0;
`endif

  always_comb begin
    state_d             = state_q;
    data_req_o          = 1'b0;
    data_addr_o         = addr_q;
    data_we_o           = we_q;
    lsu_addr_incr_req_o = 1'b0;
    done_o              = 1'b0;
    err_o               = 1'b0;
    off_cur             = offset_q;
    type_cur            = type_q;
    accept              = 1'b0;
    latch_word0         = 1'b0;
    be_hi               = 1'b0;
    rdata_valid         = 1'b0;
    case (state_q)
      IDLE: begin
        off_cur     = off_in;
        type_cur    = type_in;
        data_we_o   = lsu_we_i;
        data_addr_o = word_addr;
`ifdef LSU_MISALIGNED_EN
        accept = lsu_req_i;
`else
        accept = lsu_req_i & ~split_in;
        done_o = lsu_req_i & split_in;
        err_o  = lsu_req_i & split_in;
`endif
        data_req_o = accept;
        if (accept) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          latch_word0 = 1'b1;
          if (data_err_i || !split_q) begin
            done_o      = 1'b1;
            err_o       = data_err_i;
            rdata_valid = ~we_q;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_GNT_2;
          end
        end
      end
`ifdef LSU_MISALIGNED_EN
      WAIT_GNT_2: begin
        data_req_o          = 1'b1;
        lsu_addr_incr_req_o = 1'b1;
        data_addr_o         = word_addr;
        be_hi               = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID_2;
      end
      WAIT_RVALID_2: begin
        lsu_addr_incr_req_o = 1'b1;
        if (data_rvalid_i) begin
          done_o      = 1'b1;
          err_o       = data_err_i;
          rdata_valid = ~we_q;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign span      = be_span(type_cur, off_cur);
  assign wdata_rot = 32'({lsu_wdata_i, lsu_wdata_i} >> (6'd32 - {1'b0, off_cur, 3'b000}));
  assign data_be_o    = data_req_o ? (be_hi ? span[7:4] : span[3:0]) : 4'b0000;
  assign data_wdata_o = data_req_o ? wdata_rot : 32'h0;
  assign busy_o       = (state_q != IDLE);
  assign word0_sel    = (state_q == WAIT_RVALID_2) ? word0_q : data_rdata_i;
  assign lsu_rdata_o  = rdata_valid ? aligned : 32'h0;

  lsu_rdata_align u_align (
    .word0_i    (word0_sel),
    .word1_i    (data_rdata_i),
    .offset_i   (offset_q),
    .type_i     (type_q),
    .sign_ext_i (sign_ext_q),
    .rdata_o    (aligned)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      offset_q   <= 2'b00;
      type_q     <= LSU_WORD;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      addr_q     <= 32'h0;
      word0_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        offset_q   <= off_in;
        type_q     <= type_in;
        we_q       <= lsu_we_i;
        sign_ext_q <= lsu_sign_ext_i;
        addr_q     <= word_addr;
      end
      if (latch_word0) word0_q <= data_rdata_i;
    end
  end

endmodule
